// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory responder with bit-masked writes and fixed wait states
// Optional DMEM_RANGE_CHECK_EN: fault accesses whose address lies beyond DEPTH_WORDS words.
module dmem_responder #(
    parameter int DEPTH_WORDS = 2048,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic        i_write_enable,
    input  logic [31:0] i_write_data,
    input  logic [31:0] i_write_mask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_read_data,
    output logic        o_rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic [31:0]   data_q;
    logic [31:0]   mask_q;
    logic          oor_q;

    logic          accept;
    logic          in_idle;
    logic          enter_resp;
    logic          addr_oor;
    logic [AW-1:0] acc_idx;
    logic          acc_we;
    logic [31:0]   acc_data;
    logic [31:0]   acc_mask;
    logic          acc_oor;
    logic          unused_addr_bits;

    logic [31:0] mem [DEPTH_WORDS];

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_oor = |i_addr[31:AW+2];
`else
    assign addr_oor = 1'b0;
`endif
    assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:AW+2]};

    assign in_idle = (state == S_IDLE);
    assign accept  = i_req_valid && o_req_ready;

    // With zero wait states the access happens on the acceptance edge, so use the live request.
    assign acc_idx  = in_idle ? i_addr[AW+1:2] : idx_q;
    assign acc_we   = in_idle ? i_write_enable : we_q;
    assign acc_data = in_idle ? i_write_data   : data_q;
    assign acc_mask = in_idle ? i_write_mask   : mask_q;
    assign acc_oor  = in_idle ? addr_oor       : oor_q;

    assign enter_resp = !i_rst && (state != S_RESP) && (state_nxt == S_RESP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            idx_q  <= i_addr[AW+1:2];
            we_q   <= i_write_enable;
            data_q <= i_write_data;
            mask_q <= i_write_mask;
            oor_q  <= addr_oor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt         <= 4'd0;
            o_rsp_valid <= 1'b0;
            o_read_data <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (accept && (WAIT_STATES > 0)) begin
                cnt <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                o_rsp_valid <= 1'b1;
                o_read_data <= (acc_we || acc_oor) ? 32'd0 : mem[acc_idx];
                o_rsp_err   <= acc_oor;
            end else if ((state == S_RESP) && i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

    // Storage has no reset; a write is only blocked when reset coincides with the commit edge.
    always_ff @(posedge i_clk) begin
        if (enter_resp && acc_we && !acc_oor) begin
            mem[acc_idx] <= (mem[acc_idx] & ~acc_mask) | (acc_data & acc_mask);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=0)
module tb_dmem_responder;

    localparam int WS0 = 1;
    localparam int WS1 = 0;

    typedef struct {
        int          g;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_we    [2];
    logic [31:0] req_data  [2];
    logic [31:0] req_mask  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    time         acc_t   [2];
    logic        prev_v  [2];
    logic        prev_hs [2];
    logic [31:0] prev_d  [2];
    logic        prev_e  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(2048),
            .WAIT_STATES(g == 0 ? WS0 : WS1)
        ) dut (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_req_valid   (req_valid[g]),
            .o_req_ready   (req_ready[g]),
            .i_addr        (req_addr[g]),
            .i_write_enable(req_we[g]),
            .i_write_data  (req_data[g]),
            .i_write_mask  (req_mask[g]),
            .o_rsp_valid   (rsp_valid[g]),
            .i_rsp_ready   (rsp_ready[g]),
            .o_read_data   (rsp_data[g]),
            .o_rsp_err     (rsp_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled mid-cycle; inputs change 1ns after the rising edge.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                prev_v[g]  = 1'b0;
                prev_hs[g] = 1'b0;
            end else begin
                if (req_valid[g] && req_ready[g]) acc_t[g] = $time;
                if (rsp_valid[g] && !prev_v[g])
                    check("latency", 32'(($time - acc_t[g]) / 10), 32'((g == 0 ? WS0 : WS1) + 1));
                if (prev_v[g] && !prev_hs[g]) begin
                    check("hold_valid", 32'(rsp_valid[g]), 32'd1);
                    check("hold_data", rsp_data[g], prev_d[g]);
                    check("hold_err", 32'(rsp_err[g]), 32'(prev_e[g]));
                end
                if (prev_hs[g]) check("valid_drop", 32'(rsp_valid[g]), 32'd0);
                if (rsp_valid[g]) check("busy_ready", 32'(req_ready[g]), 32'd0);
                if (rsp_valid[g] && rsp_ready[g]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_dut", 32'(g), 32'(e.g));
                        check("rdata", rsp_data[g], e.data);
                        check("rsp_err", 32'(rsp_err[g]), 32'(e.err));
                    end
                end
                prev_v[g]  = rsp_valid[g];
                prev_hs[g] = rsp_valid[g] && rsp_ready[g];
                prev_d[g]  = rsp_data[g];
                prev_e[g]  = rsp_err[g];
            end
        end
    end

    task automatic issue(input int g, input logic [31:0] a, input logic we, input logic [31:0] d,
                         input logic [31:0] m, input logic [31:0] exp_data, input logic exp_err,
                         output time t_acc);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready[g] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_timeout", 32'(n < 100), 32'd1);
        req_valid[g] = 1'b1;
        req_addr[g]  = a;
        req_we[g]    = we;
        req_data[g]  = d;
        req_mask[g]  = m;
        sb.push_back('{g: g, data: exp_data, err: exp_err});
        t_acc = $time + 9;
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        req_we[g]    = 1'b0;
    endtask

    task automatic wr(input int g, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        time t;
        issue(g, a, 1'b1, d, m, 32'd0, 1'b0, t);
    endtask

    task automatic rd(input int g, input logic [31:0] a, input logic [31:0] exp_data);
        time t;
        issue(g, a, 1'b0, 32'd0, 32'd0, exp_data, 1'b0, t);
    endtask

    task automatic wait_rsp(input int g);
        int n = 0;
        while (!rsp_valid[g] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_rsp_timeout", 32'(rsp_valid[g]), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] model [16];
        logic [31:0] d;
        logic [31:0] m;
        int          k;
        time         t1;
        time         t2;

        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            req_addr[g]  = 32'd0;
            req_we[g]    = 1'b0;
            req_data[g]  = 32'd0;
            req_mask[g]  = 32'd0;
            rsp_ready[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check("rst_req_ready", 32'(req_ready[g]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
            check("rst_read_data", rsp_data[g], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[g]), 32'd0);
        end

        wr(0, 32'h0, 32'hdeadbeef, 32'hffffffff);
        rd(0, 32'h0, 32'hdeadbeef);

        wr(0, 32'h8, 32'hcafeb0ba, 32'hffffffff);
        wr(0, 32'ha, 32'hb0ba0000, 32'hffff0000);
        rd(0, 32'h8, 32'hb0bab0ba);
        wr(0, 32'h8, 32'hffffffff, 32'h00000000);
        rd(0, 32'h8, 32'hb0bab0ba);

        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            wr(0, 32'h100 + 32'(i * 4), model[i], 32'hffffffff);
        end
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(15, 0));
            d = $urandom;
            m = $urandom;
            model[k] = (model[k] & ~m) | (d & m);
            wr(0, 32'h100 + 32'(k * 4) + 32'($urandom_range(3, 0)), d, m);
        end
        for (int i = 0; i < 16; i++) rd(0, 32'h100 + 32'(i * 4), model[i]);
        drain();

        // Response stall: outputs must hold and fresh requests must be ignored.
        rsp_ready[0] = 1'b0;
        rd(0, 32'h0, 32'hdeadbeef);
        wait_rsp(0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8;
        req_we[0]    = 1'b1;
        req_data[0]  = 32'h0;
        req_mask[0]  = 32'hffffffff;
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_req_ready", 32'(req_ready[0]), 32'd0);
            check("stall_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        end
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        rsp_ready[0] = 1'b1;
        rd(0, 32'h8, 32'hb0bab0ba);
        drain();

        // Reset while waiting drops the write entirely.
        wr(0, 32'h4, 32'h11111111, 32'hffffffff);
        drain();
        check("rw_idle", 32'(req_ready[0]), 32'd1);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h4;
        req_we[0]    = 1'b1;
        req_data[0]  = 32'h12345678;
        req_mask[0]  = 32'hffffffff;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_wait_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        rd(0, 32'h4, 32'h11111111);
        drain();

        // Reset while responding discards the response but keeps the committed write.
        rsp_ready[0] = 1'b0;
        wr(0, 32'h4, 32'haaaa5555, 32'hffffffff);
        wait_rsp(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        rsp_ready[0] = 1'b1;
        check("rst_resp_no_rsp", 32'(rsp_valid[0]), 32'd0);
        rd(0, 32'h4, 32'haaaa5555);
        drain();

`ifdef DMEM_RANGE_CHECK_EN
        issue(0, 32'h00002000, 1'b1, 32'h5a5a5a5a, 32'hffffffff, 32'd0, 1'b1, t1);
        issue(0, 32'h00002000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, t1);
        rd(0, 32'h0, 32'hdeadbeef);
`else
        issue(0, 32'h00002000, 1'b1, 32'h5a5a5a5a, 32'hffffffff, 32'd0, 1'b0, t1);
        rd(0, 32'h0, 32'h5a5a5a5a);
`endif
        drain();

        // Zero wait states: back-to-back reads every other cycle.
        for (int i = 0; i < 4; i++) wr(1, 32'h40 + 32'(i * 4), 32'h1000_0001 * 32'(i + 1), 32'hffffffff);
        issue(1, 32'h40, 1'b0, 32'd0, 32'd0, 32'h1000_0001, 1'b0, t1);
        for (int i = 1; i < 4; i++) begin
            issue(1, 32'h40 + 32'(i * 4), 1'b0, 32'd0, 32'd0, 32'h1000_0001 * 32'(i + 1), 1'b0, t2);
            check("b2b_spacing", 32'(t2 - t1), 32'd20);
            t1 = t2;
        end
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 2048, meaning number of 32-bit storage words (power of two); AW = log2(DEPTH_WORDS).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port i_clk  input  1  rising-edge clock; the block has one clock, i_clk.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous to i_clk and active-high.
REQ-005 SHALL have port i_req_valid  input  1  request present.
REQ-006 SHALL have port o_req_ready  output  1  block can accept a request.
REQ-007 SHALL have port i_addr  input  32  byte address; word index = i_addr[AW+1:2], bits [1:0] ignored.
REQ-008 SHALL have port i_write_enable  input  1  1 = write, 0 = read.
REQ-009 SHALL have port i_write_data  input  32  store data, already lane-aligned.
REQ-010 SHALL have port i_write_mask  input  32  bit-granular write mask; 1 = update that bit.
REQ-011 SHALL have port o_rsp_valid  output  1  response present.
REQ-012 SHALL have port i_rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port o_read_data  output  32  full word read; 0 for writes and errors.
REQ-014 SHALL have port o_rsp_err  output  1  access faulted.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP; o_req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with i_req_valid & o_req_ready, and SHALL register addr, write_enable, data and mask on that edge.
REQ-017 SHALL, on acceptance, go to WAIT with counter = WAIT_STATES when WAIT_STATES > 0, else directly to RESP.
REQ-018 SHALL decrement the counter once per cycle in WAIT and SHALL go to RESP on the edge where the counter equals 1.
REQ-019 SHALL make o_rsp_valid first high exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-020 SHALL perform the storage access on the edge entering RESP: write = mem <= (mem & ~mask) | (data & mask); read = capture the word into the o_read_data register.
REQ-021 SHALL hold o_rsp_valid, o_read_data and o_rsp_err stable in RESP until i_rsp_ready; on that edge return to IDLE with o_rsp_valid = 0.
REQ-022 SHALL not accept a new request on the response-handshake edge; the minimum request spacing is WAIT_STATES+2 cycles.
REQ-023 SHALL ignore all request inputs while not in IDLE.
REQ-024 SHALL treat an all-zero write mask as a valid write that changes no storage and responds normally.
REQ-025 SHALL keep storage contents uninitialised; storage is not affected by reset.

Reset
REQ-026 SHALL, when i_rst is high at a rising edge, go to IDLE and set o_rsp_valid = 0, o_read_data = 0, o_rsp_err = 0, counter = 0; o_req_ready = 1 from the following cycle.
REQ-027 SHALL drop an in-flight transaction if reset occurs in WAIT: no storage write occurs and no response is produced.
REQ-028 SHALL discard a pending response if reset occurs in RESP; a write completed on entering RESP stays committed.

Configuration
REQ-029 SHALL provide macro DMEM_RANGE_CHECK_EN; when defined, any of i_addr[31:AW+2] nonzero marks the transaction out-of-range.
REQ-030 SHALL, for an out-of-range transaction, perform no storage write, return o_read_data = 0 and o_rsp_err = 1, with the same latency as a normal transaction.
REQ-031 SHALL, without DMEM_RANGE_CHECK_EN, ignore the upper address bits (the address wraps modulo DEPTH_WORDS*4) and tie o_rsp_err to 0.

Verification
REQ-032 SHALL be verified by: WAIT_STATES=1, write 0xdeadbeef to addr 0x0 with mask 0xffffffff, then read 0x0 -> o_rsp_valid 2 cycles after each acceptance; read data 0xdeadbeef; o_rsp_err 0.
REQ-033 SHALL be verified by: word at 0x8 = 0xcafeb0ba, write data 0xb0ba0000 with mask 0xffff0000 to addr 0xa, then read 0x8 -> 0xb0bab0ba.
REQ-034 SHALL be verified by: i_rsp_ready held low for 5 cycles in RESP -> o_rsp_valid and data held for 5 cycles; o_req_ready 0 throughout; new i_req_valid ignored.
REQ-035 SHALL be verified by: WAIT_STATES=0, back-to-back reads with i_rsp_ready tied high -> responses 1 cycle after acceptance; accepted requests spaced 2 cycles apart.
REQ-036 SHALL be verified by: i_rst asserted in WAIT during a write of 0x12345678 to 0x4 -> o_rsp_valid stays 0; a later read of 0x4 returns the prior value.
REQ-037 SHALL be verified by: with DMEM_RANGE_CHECK_EN and DEPTH_WORDS=2048, write to 0x00002000 -> o_rsp_err 1, o_read_data 0, word 0 unchanged; without the macro, the same write updates word 0.
